// File: rtl/multi_edge_detector.sv
// Multi-channel input conditioner: synchroniser, glitch filter, per-channel edge pulse and sticky flag.
// Optional: define DET_EVENT_COUNT_EN to add saturating 8-bit per-channel event counters on det_count.
module multi_edge_detector #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int IDLE_LEVEL  = 1
) (
   input  logic                  det_clk,
   input  logic                  det_rst,
   input  logic [CHANNELS-1:0]   det_input,
   input  logic [2*CHANNELS-1:0] det_mode,
   input  logic [CHANNELS-1:0]   det_clear,
   output logic [CHANNELS-1:0]   det_output,
   output logic [CHANNELS-1:0]   det_level,
   output logic [CHANNELS-1:0]   det_sticky,
`ifdef DET_EVENT_COUNT_EN
   output logic [8*CHANNELS-1:0] det_count,
`endif
   output logic                  det_any
);

   localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
   localparam logic             IDLE     = (IDLE_LEVEL != 0);

   logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
   logic [CNT_W-1:0]       r_cnt  [CHANNELS];
   logic [CHANNELS-1:0]    r_level;
   logic [CHANNELS-1:0]    r_output;
   logic [CHANNELS-1:0]    r_sticky;

   logic [CHANNELS-1:0]    w_sample;
   logic [CHANNELS-1:0]    w_accept;
   logic [CHANNELS-1:0]    w_pulse;

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      w_sample = '0;
      w_accept = '0;
      w_pulse  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_sample[i] = r_sync[i][SYNC_STAGES-1];
         w_accept[i] = (w_sample[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
         // Mode bit 0 enables rising (new level 1), bit 1 enables falling (new level 0).
         w_pulse[i]  = w_accept[i] && (w_sample[i] ? det_mode[2*i] : det_mode[2*i+1]);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge det_clk or posedge det_rst) begin
      if (det_rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_sync[i] <= {SYNC_STAGES{IDLE}};
            r_cnt[i]  <= '0;
         end
         r_level  <= {CHANNELS{IDLE}};
         r_output <= '0;
         r_sticky <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], det_input[i]};
            if (w_sample[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_level[i] <= w_sample[i];
               r_cnt[i]   <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
         r_output <= w_pulse;
         // A new event beats a simultaneous clear so nothing is lost.
         r_sticky <= w_pulse | (r_sticky & ~det_clear);
      end
   end

`ifdef DET_EVENT_COUNT_EN
   logic [7:0] r_count [CHANNELS];

   always_ff @(posedge det_clk or posedge det_rst) begin
      if (det_rst) begin
         for (int i = 0; i < CHANNELS; i++) r_count[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (det_clear[i]) begin
               r_count[i] <= {7'd0, w_pulse[i]};
            end else if (w_pulse[i] && (r_count[i] != 8'hFF)) begin
               r_count[i] <= r_count[i] + 8'd1;
            end
         end
      end
   end

   always_comb begin
      det_count = '0;
      for (int i = 0; i < CHANNELS; i++) det_count[8*i +: 8] = r_count[i];
   end
`endif

   assign det_output = r_output;
   assign det_level  = r_level;
   assign det_sticky = r_sticky;
   assign det_any    = |r_sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: scheduled level/pulse events are queued when inputs are driven
// and retired at the edge where the filter must accept them; every cycle all outputs are checked.
module tb_multi_edge_detector;

   localparam int CH  = 4;
   localparam int LAT = 5;

   logic            det_clk = 1'b0;
   logic            det_rst;
   logic [CH-1:0]   det_input;
   logic [2*CH-1:0] det_mode;
   logic [CH-1:0]   det_clear;
   logic [CH-1:0]   det_output;
   logic [CH-1:0]   det_level;
   logic [CH-1:0]   det_sticky;
   logic            det_any;
`ifdef DET_EVENT_COUNT_EN
   logic [8*CH-1:0] det_count;
   logic [7:0]      exp_count [CH];
`endif

   multi_edge_detector dut (
      .det_clk    (det_clk),
      .det_rst    (det_rst),
      .det_input  (det_input),
      .det_mode   (det_mode),
      .det_clear  (det_clear),
      .det_output (det_output),
      .det_level  (det_level),
      .det_sticky (det_sticky),
`ifdef DET_EVENT_COUNT_EN
      .det_count  (det_count),
`endif
      .det_any    (det_any)
   );

   always #5 det_clk = ~det_clk;

   typedef struct {
      int   cyc;
      int   ch;
      logic lvl;
      logic pulse;
   } ev_t;

   ev_t           sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   string         phase    = "reset";
   logic [CH-1:0] exp_out;
   logic [CH-1:0] exp_level;
   logic [CH-1:0] exp_sticky;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      check({phase, "_output"}, 32'(det_output), 32'(exp_out));
      check({phase, "_level"},  32'(det_level),  32'(exp_level));
      check({phase, "_sticky"}, 32'(det_sticky), 32'(exp_sticky));
      check({phase, "_any"},    32'(det_any),    32'(|exp_sticky));
`ifdef DET_EVENT_COUNT_EN
      for (int i = 0; i < CH; i++)
         check({phase, "_count"}, 32'(det_count[8*i +: 8]), 32'(exp_count[i]));
`endif
   endtask

   task automatic model_reset();
      sb.delete();
      exp_out    = '0;
      exp_level  = '1;
      exp_sticky = '0;
`ifdef DET_EVENT_COUNT_EN
      for (int i = 0; i < CH; i++) exp_count[i] = '0;
`endif
   endtask

   // One clock: capture the clear seen at the edge, retire due events, then check every output.
   task automatic tick();
      logic [CH-1:0] clr;
      ev_t           e;
      clr = det_clear;
      @(posedge det_clk);
      #1;
      cyc++;
      exp_out    = '0;
      exp_sticky = exp_sticky & ~clr;
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         exp_level[e.ch] = e.lvl;
         if (e.pulse) begin
            exp_out[e.ch]    = 1'b1;
            exp_sticky[e.ch] = 1'b1;
         end
      end
`ifdef DET_EVENT_COUNT_EN
      for (int i = 0; i < CH; i++) begin
         if (clr[i])                                exp_count[i] = {7'd0, exp_out[i]};
         else if (exp_out[i] && exp_count[i] != 8'hFF) exp_count[i] = exp_count[i] + 8'd1;
      end
`endif
      check_all();
   endtask

   // Drive one channel; an accepted change is due LAT edges later, pulsing if the mode enables that direction.
   task automatic set_in(input int ch, input logic val, input bit accepted);
      logic [1:0] m;
      det_input[ch] = val;
      m = det_mode[2*ch +: 2];
      if (accepted) sb.push_back(ev_t'{cyc + LAT, ch, val, (val ? m[0] : m[1])});
   endtask

   initial begin
      det_rst   = 1'b1;
      det_input = '1;
      det_mode  = {2'b01, 2'b00, 2'b11, 2'b10};
      det_clear = '0;
      model_reset();

      phase = "reset";
      repeat (2) tick();
      det_rst = 1'b0;
      phase = "idle";
      repeat (10) tick();

      phase = "ch0_fall";
      set_in(0, 1'b0, 1'b1);
      repeat (8) tick();

      phase = "ch1_glitch";
      set_in(1, 1'b0, 1'b0);
      repeat (2) tick();
      set_in(1, 1'b1, 1'b0);
      repeat (6) tick();
      phase = "ch1_pulse";
      set_in(1, 1'b0, 1'b1);
      repeat (5) tick();
      set_in(1, 1'b1, 1'b1);
      repeat (8) tick();

      phase = "ch2_off";
      set_in(2, 1'b0, 1'b1);
      repeat (8) tick();
      set_in(2, 1'b1, 1'b1);
      repeat (8) tick();

      phase = "ch3_clear";
      set_in(3, 1'b0, 1'b1);
      repeat (8) tick();
      set_in(3, 1'b1, 1'b1);
      repeat (4) tick();
      det_clear[3] = 1'b1;
      repeat (2) tick();
      det_clear[3] = 1'b0;
      repeat (3) tick();

      phase = "mid_reset";
      set_in(0, 1'b1, 1'b1);
      repeat (4) tick();
      det_rst   = 1'b1;
      det_input = '1;
      model_reset();
      #1;
      check_all();
      repeat (2) tick();
      det_rst = 1'b0;
      phase = "post_reset";
      repeat (10) tick();

`ifdef DET_EVENT_COUNT_EN
      phase = "count_sat";
      det_mode[1:0] = 2'b11;
      for (int k = 0; k < 300; k++) begin
         set_in(0, ~det_input[0], 1'b1);
         repeat (6) tick();
      end
      repeat (6) tick();
      check("count_final", 32'(det_count[7:0]), 32'd255);
`endif

      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
